// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store sequencer between the core and the data-memory port.
// Accepts one request in IDLE, issues one or two aligned word beats with byte enables,
// waits for mem_ack under a bounded wait counter, then pulses done with the extended result.
// Optional feature macro: LSU_SPLIT_EN. When defined, word-crossing H/W accesses are split
// into BEAT0+BEAT1. When undefined, misaligned H/W accesses are rejected with misalign=1.
module lsu_ctrl #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic            misalign,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam int WW = $clog2(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Lane mask for an access size (func3[1:0]).
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Sign- or zero-extend a lane-0 aligned load word according to func3.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] w, input logic [2:0] f3);
    logic [XLEN-1:0] r;
    case (f3)
      3'b000:  r = {{(XLEN-8){w[7]}}, w[7:0]};
      3'b001:  r = {{(XLEN-16){w[15]}}, w[15:0]};
      3'b100:  r = {{(XLEN-8){1'b0}}, w[7:0]};
      3'b101:  r = {{(XLEN-16){1'b0}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  state_e          state_q;
  logic            we_q;
  logic [2:0]      func3_q;
  logic [1:0]      off_q;
  logic [WW-1:0]   wait_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic            misalign_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [3:0]      mem_be_q;
  logic [XLEN-1:0] mem_wdata_q;

  logic [3:0]      mask_s;
  logic [3:0]      be_lo_s;
  logic [XLEN-1:0] wdata_lo_s;
  logic            illegal_s;
  logic [XLEN-1:0] load_word_s;
  logic [XLEN-1:0] load_res_s;

  // Decode the incoming request: first-beat lanes, shifted store data, legality.
  always_comb begin
    mask_s     = size_mask(func3[1:0]);
    be_lo_s    = mask_s << addr[1:0];
    wdata_lo_s = wdata << {addr[1:0], 3'b000};
    case (func3)
      3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
      3'b100, 3'b101:         illegal_s = we;
      default:                illegal_s = 1'b1;
    endcase
  end

`ifdef LSU_SPLIT_EN
  logic            cross_q;
  logic [3:0]      be_hi_q;
  logic [XLEN-1:0] wdata_hi_q;
  logic [XLEN-1:0] data0_q;
  logic [2:0]      back_s;
  logic [3:0]      be_hi_s;
  logic [XLEN-1:0] wdata_hi_s;

  // Lanes and store bytes that spill past lane 3 into the next word.
  always_comb begin
    back_s     = 3'd4 - {1'b0, addr[1:0]};
    be_hi_s    = mask_s >> back_s;
    wdata_hi_s = wdata >> {back_s, 3'b000};
  end
`else
  logic misaligned_s;

  // Halfwords on odd bytes and words off a word boundary cannot be served in one beat.
  always_comb begin
    if (func3[1:0] == 2'b01) begin
      misaligned_s = addr[0];
    end else if (func3[1:0] == 2'b10) begin
      misaligned_s = (addr[1:0] != 2'b00);
    end else begin
      misaligned_s = 1'b0;
    end
  end
`endif

  // Bring the loaded bytes down to lane 0 (merging both beats when split) and extend.
  always_comb begin
`ifdef LSU_SPLIT_EN
    if (state_q == S_BEAT1) begin
      load_word_s = (data0_q >> {off_q, 3'b000}) |
                    (mem_rdata << {3'd4 - {1'b0, off_q}, 3'b000});
    end else begin
      load_word_s = mem_rdata >> {off_q, 3'b000};
    end
`else
    load_word_s = mem_rdata >> {off_q, 3'b000};
`endif
    if (we_q) begin
      load_res_s = {XLEN{1'b0}};
    end else begin
      load_res_s = extend(load_word_s, func3_q);
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      func3_q     <= 3'b000;
      off_q       <= 2'b00;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= {XLEN{1'b0}};
      err_q       <= 1'b0;
      misalign_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {XLEN{1'b0}};
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= {XLEN{1'b0}};
`ifdef LSU_SPLIT_EN
      cross_q     <= 1'b0;
      be_hi_q     <= 4'b0000;
      wdata_hi_q  <= {XLEN{1'b0}};
      data0_q     <= {XLEN{1'b0}};
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            func3_q <= func3;
            off_q   <= addr[1:0];
            busy_q  <= 1'b1;
`ifdef LSU_SPLIT_EN
            cross_q    <= (be_hi_s != 4'b0000);
            be_hi_q    <= be_hi_s;
            wdata_hi_q <= wdata_hi_s;
`endif
            if (illegal_s) begin
              state_q <= S_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
`ifndef LSU_SPLIT_EN
            end else if (misaligned_s) begin
              state_q    <= S_RESP;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
`endif
            end else begin
              state_q     <= S_BEAT0;
              wait_q      <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= we;
              mem_addr_q  <= {addr[XLEN-1:2], 2'b00};
              mem_be_q    <= be_lo_s;
              mem_wdata_q <= wdata_lo_s;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_BEAT0: begin
`ifdef LSU_SPLIT_EN
          if (mem_ack && cross_q) begin
            state_q     <= S_BEAT1;
            wait_q      <= '0;
            data0_q     <= mem_rdata;
            mem_addr_q  <= mem_addr_q + 32'd4;
            mem_be_q    <= be_hi_q;
            mem_wdata_q <= wdata_hi_q;
          end else
`endif
          if (mem_ack) begin
            state_q     <= S_RESP;
            done_q      <= 1'b1;
            rdata_q     <= load_res_s;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {XLEN{1'b0}};
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= {XLEN{1'b0}};
          end else if (wait_q == WAIT_LAST) begin
            state_q     <= S_RESP;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= {XLEN{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {XLEN{1'b0}};
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= {XLEN{1'b0}};
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
`ifdef LSU_SPLIT_EN
        S_BEAT1: begin
          if (mem_ack) begin
            state_q     <= S_RESP;
            done_q      <= 1'b1;
            rdata_q     <= load_res_s;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {XLEN{1'b0}};
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= {XLEN{1'b0}};
          end else if (wait_q == WAIT_LAST) begin
            state_q     <= S_RESP;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= {XLEN{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {XLEN{1'b0}};
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= {XLEN{1'b0}};
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
`endif
        S_RESP: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          misalign_q <= 1'b0;
          rdata_q    <= {XLEN{1'b0}};
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
          misalign_q  <= 1'b0;
          rdata_q     <= {XLEN{1'b0}};
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= {XLEN{1'b0}};
          mem_be_q    <= 4'b0000;
          mem_wdata_q <= {XLEN{1'b0}};
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign misalign  = misalign_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected beats and responses,
// a negedge memory responder/monitor pops and compares them.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  lsu_ctrl #(.XLEN(32), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .func3(func3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          reqc;
    int          dcyc;
  } resp_t;

  beat_t       beat_q[$];
  resp_t       resp_q[$];
  logic [31:0] rd_q[$];
  int          ack_wait = 0;
  int          wait_cnt = 0;
  int          req_cycles = 0;
  int          cyc = 0;
  int          tests = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder and output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    resp_t r;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    if (!rst) begin
      wait_cnt   = 0;
      req_cycles = 0;
    end else begin
      if (mem_req) begin
        req_cycles++;
        if (wait_cnt >= ack_wait) begin
          mem_ack = 1'b1;
          if (rd_q.size() > 0) mem_rdata = rd_q.pop_front();
          wait_cnt = 0;
          if (beat_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_beat: addr 0x%08h be %b", mem_addr, mem_be);
          end else begin
            b = beat_q.pop_front();
            check("beat_addr", mem_addr, b.addr);
            check("beat_be", {28'h0, mem_be}, {28'h0, b.be});
            check("beat_we", {31'h0, mem_we}, {31'h0, b.we});
            check("beat_wdata", mem_wdata, b.wdata);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      if (done) begin
        if (resp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_done: rdata 0x%08h err %b", rdata, err);
        end else begin
          r = resp_q.pop_front();
          check("rdata", rdata, r.rdata);
          check("err", {31'h0, err}, {31'h0, r.err});
          check("misalign", {31'h0, misalign}, {31'h0, r.mis});
          check("mem_req_cycles", req_cycles, r.reqc);
          check("done_cycle", cyc, r.dcyc);
          check("busy_at_done", {31'h0, busy}, 32'h1);
        end
        req_cycles = 0;
      end
    end
  end

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic w,
                           input logic [31:0] d);
    beat_t b;
    b.addr = a; b.be = be; b.we = w; b.wdata = d;
    beat_q.push_back(b);
  endtask

  // Issue one request, holding req until done (exercises req-while-busy being ignored).
  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                       input logic exp_mis, input int exp_reqc, input int lat);
    resp_t r;
    bit seen;
    @(negedge clk);
    r.rdata = exp_rd; r.err = exp_err; r.mis = exp_mis; r.reqc = exp_reqc;
    r.dcyc = cyc + lat;
    resp_q.push_back(r);
    req = 1'b1; we = w; func3 = f; addr = a; wdata = d;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    req = 1'b0;
    if (!seen) begin
      tests++;
      errors++;
      $display("FAIL done_timeout: addr 0x%08h func3 %b", a, f);
      beat_q.delete();
      resp_q.delete();
      rd_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; func3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy_done", {30'h0, busy, done}, 32'h0);
    check("rst_mem", {27'h0, mem_req, mem_be}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err_mis", {30'h0, err, misalign}, 32'h0);
    rst = 1'b1;

    // Aligned LW, ack in the same cycle
    ack_wait = 0;
    push_beat(32'h100, 4'b1111, 1'b0, 32'h0); rd_q.push_back(32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1, 2);
    // LB / LBU at top lane
    push_beat(32'h200, 4'b1000, 1'b0, 32'h0); rd_q.push_back(32'h80112233);
    issue(1'b0, 3'b000, 32'h203, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 1, 2);
    push_beat(32'h200, 4'b1000, 1'b0, 32'h0); rd_q.push_back(32'h80112233);
    issue(1'b0, 3'b100, 32'h203, 32'h0, 32'h00000080, 1'b0, 1'b0, 1, 2);
    // SH upper half
    push_beat(32'h300, 4'b1100, 1'b1, 32'hABCD0000);
    issue(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 1'b0, 1'b0, 1, 2);
    // LH / LHU with two wait cycles, then no wait
    ack_wait = 2;
    push_beat(32'h104, 4'b1100, 1'b0, 32'h0); rd_q.push_back(32'h9ABC0000);
    issue(1'b0, 3'b001, 32'h106, 32'h0, 32'hFFFF9ABC, 1'b0, 1'b0, 3, 4);
    ack_wait = 0;
    push_beat(32'h104, 4'b1100, 1'b0, 32'h0); rd_q.push_back(32'h9ABC0000);
    issue(1'b0, 3'b101, 32'h106, 32'h0, 32'h00009ABC, 1'b0, 1'b0, 1, 2);
    // SB lane 1, SW aligned, LB positive
    push_beat(32'h010, 4'b0010, 1'b1, 32'h0000A500);
    issue(1'b1, 3'b000, 32'h011, 32'h000000A5, 32'h0, 1'b0, 1'b0, 1, 2);
    push_beat(32'h020, 4'b1111, 1'b1, 32'h12345678);
    issue(1'b1, 3'b010, 32'h020, 32'h12345678, 32'h0, 1'b0, 1'b0, 1, 2);
    push_beat(32'h100, 4'b0100, 1'b0, 32'h0); rd_q.push_back(32'h007F0000);
    issue(1'b0, 3'b000, 32'h102, 32'h0, 32'h0000007F, 1'b0, 1'b0, 1, 2);
    // Illegal encodings: no memory beat
    issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1);
    issue(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1);
    issue(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1);
`ifdef LSU_SPLIT_EN
    push_beat(32'h400, 4'b1110, 1'b0, 32'h0); rd_q.push_back(32'h44332211);
    push_beat(32'h404, 4'b0001, 1'b0, 32'h0); rd_q.push_back(32'h88776655);
    issue(1'b0, 3'b010, 32'h401, 32'h0, 32'h55443322, 1'b0, 1'b0, 2, 3);
    push_beat(32'h100, 4'b1000, 1'b0, 32'h0); rd_q.push_back(32'h11223344);
    push_beat(32'h104, 4'b0001, 1'b0, 32'h0); rd_q.push_back(32'h55667788);
    issue(1'b0, 3'b001, 32'h103, 32'h0, 32'hFFFF8811, 1'b0, 1'b0, 2, 3);
    push_beat(32'hFFFFFFFC, 4'b1000, 1'b1, 32'hCD000000);
    push_beat(32'h00000000, 4'b0001, 1'b1, 32'h000000AB);
    issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 32'h0, 1'b0, 1'b0, 2, 3);
    push_beat(32'h100, 4'b0110, 1'b0, 32'h0); rd_q.push_back(32'h00BEEF00);
    issue(1'b0, 3'b001, 32'h101, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b0, 1, 2);
`else
    issue(1'b0, 3'b010, 32'h401, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1);
    issue(1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1);
    issue(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 32'h0, 1'b0, 1'b1, 0, 1);
    issue(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1);
`endif
    // Timeout: no ack ever
    ack_wait = 1000;
    issue(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 1'b1, 1'b0, 16, 17);

    // Reset during BEAT0 aborts without done
    @(negedge clk);
    req = 1'b1; we = 1'b0; func3 = 3'b010; addr = 32'h600;
    @(negedge clk);
    req = 1'b0;
    check("beat0_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_mem_req", {31'h0, mem_req}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    repeat (5) @(negedge clk);
    check("idle_busy", {31'h0, busy}, 32'h0);
    check("beats_left", beat_q.size(), 32'h0);
    check("resps_left", resp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the core datapath and the data-memory port. Used for LOAD/STORE opcodes.
- Takes one access request from ctrl, drives aligned word accesses with byte enables, and waits on a memory ack handshake.
- Shifts store data into the correct lanes; extracts, merges and sign- or zero-extends load data.
- Raises busy to stall the core and pulses done when the result is ready. Bounded by a wait-timeout counter.

Parameters:
XLEN, 32, data/address width (only 32 supported)
MAX_WAIT, 16, cycles a beat may wait for mem_ack before timeout error (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
req  in  1  access request; sampled only in IDLE
we  in  1  1=store, 0=load
func3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU load-only)
addr  in  XLEN  byte address (rs1+imm)
wdata  in  XLEN  store data (rs2)
busy  out  1  high from the cycle after an accepted req through RESP
done  out  1  one-cycle completion pulse
rdata  out  XLEN  extended load result; valid while done=1, else 0
err  out  1  valid with done: illegal func3 or timeout
misalign  out  1  valid with done: misaligned access rejected
mem_req  out  1  memory beat request
mem_we  out  1  beat is a write
mem_addr  out  XLEN  word-aligned address, bits[1:0]=00
mem_be  out  4  byte enables
mem_wdata  out  XLEN  lane-shifted write data
mem_rdata  in  XLEN  read word, valid with mem_ack
mem_ack  in  1  beat complete; may assert in the same cycle as mem_req

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; all outputs 0; latched request and wait counter cleared.
- Reset mid-operation aborts the access: no done, mem_req low after that edge.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req=1: latch we, func3, addr, wdata, off=addr[1:0].
  - Illegal func3 (011, 11x, or store with func3[2]=1): go RESP with err=1, no memory beat.
  - Misaligned access: go RESP with misalign=1 when LSU_SPLIT_EN is not defined (see Optional Feature).
  - Otherwise go BEAT0.
- BEAT0:
  - Drive mem_req=1, mem_addr={addr[31:2],00}, mem_we=we.
  - mem_be = size mask << off, truncated to 4 bits. Size mask: B=0001, H=0011, W=1111.
  - mem_wdata = wdata << 8*off.
  - Hold all mem outputs stable until mem_ack.
  - On mem_ack: capture mem_rdata. Go BEAT1 if the access crosses a word, else RESP.
- BEAT1:
  - mem_addr = beat0 address + 4.
  - mem_be = bits of the size mask shifted past lane 3.
  - mem_wdata = wdata >> 8*(4-off).
  - On mem_ack: merge the captured bytes and go RESP.
- Wait counter:
  - Cleared on entry to each beat; increments each cycle mem_ack=0.
  - Reaching MAX_WAIT: drop mem_req, go RESP with err=1, rdata=0.
- RESP:
  - done=1 for exactly one cycle, then IDLE.
  - rdata = loaded bytes shifted down by 8*off, then extended. B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
  - rdata=0 for stores and errors.
- busy: 1 in BEAT0, BEAT1 and RESP; 0 in IDLE.
- Latency, aligned access with mem_ack in the same cycle: req at edge N, BEAT0 cycle N+1, done at cycle N+2.
- Each extra wait cycle adds 1; a split access adds at least 1 more.
- req while busy is ignored; the core holds its request until done.
- Back-to-back: req may be reasserted in the cycle after done.
- Address wrap: beat1 address is computed modulo 2^32.

Optional Feature:
- Macro LSU_SPLIT_EN.
- Defined:
  - H with off=3 and W with off!=0 split into BEAT0+BEAT1.
  - H with off=1 is a single beat, be=0110.
  - misaligned output is tied 0.
- Not defined:
  - H with addr[0]=1, or W with off!=0, performs no memory beat.
  - done pulses one cycle after req (via RESP) with misalign=1, err=0, rdata=0.
  - BEAT1 is not built.

Test Plan:
- Aligned LW, addr=0x100, mem_rdata=0xDEADBEEF, ack same cycle -> mem_be=1111, mem_addr=0x100; done 2 cycles after req; rdata=0xDEADBEEF.
- LB, addr=0x203, mem_rdata=0x80112233 -> be=1000; rdata=0xFFFFFF80. LBU same stimulus -> rdata=0x00000080.
- SH, addr=0x302, wdata=0x0000ABCD -> mem_we=1, be=1100, mem_wdata=0xABCD0000, rdata=0, err=0.
- LW, addr=0x401, mem reads 0x44332211 then 0x88776655:
  - LSU_SPLIT_EN defined -> beats at 0x400 be=1110, then 0x404 be=0001; rdata=0x55443322.
  - Not defined -> no mem_req; misalign=1 with done.
- mem_ack held 0 -> mem_req held MAX_WAIT=16 cycles, then done with err=1, rdata=0. func3=011 -> err=1 with no beat. rst=0 during BEAT0 -> next cycle IDLE, busy=0, no done.
